// File: rtl/rv_regfile_mp_if.sv
// rv_regfile_mp_if: write, read, issue and clear signals of the multi-port register file.
// Parity ports exist only when RVX_RF_PARITY_EN is defined.
interface rv_regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_ready;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     clr_req;
    logic                     clr_busy;
`ifdef RVX_RF_PARITY_EN
    logic [NUM_RD-1:0]        rd_perr;
    logic                     perr_inject;
`endif

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr, clr_req,
`ifdef RVX_RF_PARITY_EN
        output perr_inject,
        input  rd_perr,
`endif
        input  rd_data, rd_ready, clr_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr, clr_req,
`ifdef RVX_RF_PARITY_EN
        input  perr_inject,
        output rd_perr,
`endif
        output rd_data, rd_ready, clr_busy
    );
endinterface

// File: rtl/rv_regfile_mp.sv
// rv_regfile_mp: multi-port register file with busy scoreboard, write-to-read bypass and sequenced clear.
// Define RVX_RF_PARITY_EN to add per-entry even parity with rd_perr/perr_inject.
module rv_regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input logic            clk,
    input logic            rst,
    rv_regfile_mp_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
`ifdef RVX_RF_PARITY_EN
    logic [DEPTH-1:0]  par_q, par_d;
`endif
    logic              clearing;
    logic [ADDR_W-1:0] wa, ra;
    logic [DATA_W-1:0] byp;
    logic              hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (bus.clr_req) begin
                state_d = CLEAR;
                cnt_d   = ADDR_W'(1);
            end
        end else begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(DEPTH - 1))
                state_d = IDLE;
        end
    end

    always_comb begin
        clearing     = (state_q == CLEAR);
        bus.clr_busy = clearing;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
`ifdef RVX_RF_PARITY_EN
            par_q  <= '0;
`endif
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
`ifdef RVX_RF_PARITY_EN
            par_q  <= par_d;
`endif
        end
    end

    // Later write ports overwrite earlier ones; the issue mark is applied last so a new producer wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        wa     = '0;
`ifdef RVX_RF_PARITY_EN
        par_d  = par_q;
`endif
        if (clearing) begin
            regs_d[cnt_q] = '0;
            busy_d[cnt_q] = 1'b0;
`ifdef RVX_RF_PARITY_EN
            par_d[cnt_q]  = 1'b0;
`endif
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                wa = bus.wr_addr[k*ADDR_W +: ADDR_W];
                if (bus.wr_en[k] && wa != '0) begin
                    regs_d[wa] = bus.wr_data[k*DATA_W +: DATA_W];
                    busy_d[wa] = 1'b0;
`ifdef RVX_RF_PARITY_EN
                    par_d[wa]  = (^bus.wr_data[k*DATA_W +: DATA_W]) ^ (k == 0 && bus.perr_inject);
`endif
                end
            end
            if (bus.iss_en && bus.iss_addr != '0)
                busy_d[bus.iss_addr] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
`ifdef RVX_RF_PARITY_EN
        par_d[0]  = 1'b0;
`endif
    end

    always_comb begin
        bus.rd_data  = '0;
        bus.rd_ready = '0;
`ifdef RVX_RF_PARITY_EN
        bus.rd_perr  = '0;
`endif
        ra  = '0;
        byp = '0;
        hit = 1'b0;
        for (int r = 0; r < NUM_RD; r++) begin
            ra  = bus.rd_addr[r*ADDR_W +: ADDR_W];
            byp = '0;
            hit = 1'b0;
            for (int k = 0; k < NUM_WR; k++) begin
                if (bus.wr_en[k] && bus.wr_addr[k*ADDR_W +: ADDR_W] == ra) begin
                    hit = 1'b1;
                    byp = bus.wr_data[k*DATA_W +: DATA_W];
                end
            end
            hit = hit && !clearing && ra != '0;
            bus.rd_data[r*DATA_W +: DATA_W] = (ra == '0) ? '0 : hit ? byp : regs_q[ra];
            bus.rd_ready[r] = !clearing && (ra == '0 || hit || !busy_q[ra]);
`ifdef RVX_RF_PARITY_EN
            bus.rd_perr[r]  = !clearing && ra != '0 && !hit && (par_q[ra] != ^regs_q[ra]);
`endif
        end
    end
endmodule

// File: tb/tb_rv_regfile_mp.sv
// tb_rv_regfile_mp: scoreboard bench for rv_regfile_mp; expectations are queued with the stimulus
// and popped against the DUT outputs a few ns later in the same cycle.
module tb_rv_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        string       tag;
        int          kind;
        int          port;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    rv_regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .NUM_WR(2)) bus ();

    rv_regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .NUM_WR(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en    = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
        bus.clr_req  = 1'b0;
`ifdef RVX_RF_PARITY_EN
        bus.perr_inject = 1'b0;
`endif
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        bus.rd_addr[p*AW +: AW] = a;
    endtask

    task automatic set_wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_en[k] = 1'b1;
        bus.wr_addr[k*AW +: AW] = a;
        bus.wr_data[k*DW +: DW] = d;
    endtask

    task automatic exp_rd(input string tag, input int p, input logic [31:0] d, input logic r);
        sb.push_back('{tag: {tag, "_data"}, kind: 0, port: p, val: d});
        sb.push_back('{tag: {tag, "_rdy"}, kind: 1, port: p, val: {31'b0, r}});
    endtask

    task automatic exp_kind(input string tag, input int kind, input int p, input logic v);
        sb.push_back('{tag: tag, kind: kind, port: p, val: {31'b0, v}});
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = '0;
            if (e.kind == 0) obs = bus.rd_data[e.port*DW +: DW];
            else if (e.kind == 1) obs = {31'b0, bus.rd_ready[e.port]};
            else if (e.kind == 2) obs = {31'b0, bus.clr_busy};
`ifdef RVX_RF_PARITY_EN
            else obs = {31'b0, bus.rd_perr[e.port]};
`endif
            check(e.tag, obs, e.val);
        end
    endtask

    function automatic logic [31:0] fill(input int i);
        return 32'hA5A5_0000 | i;
    endfunction

    initial begin
        int n;
        idle();
        bus.rd_addr = '0;
        #1 rst = 1'b0;
        set_rd(0, 5);
        set_rd(1, 0);
        #1;
        exp_rd("rst_p0", 0, 32'h0, 1'b1);
        exp_rd("rst_p1", 1, 32'h0, 1'b1);
        exp_kind("rst_cb", 2, 0, 1'b0);
        drain();
        tick();
        tick();
        rst = 1'b1;
        tick();

        set_wr(0, 5, 32'hDEAD_BEEF);
        tick();
        idle();
        set_rd(1, 5);
        set_rd(0, 0);
        exp_rd("basic_x5", 1, 32'hDEAD_BEEF, 1'b1);
        exp_rd("basic_x0", 0, 32'h0, 1'b1);
        drain();

        set_wr(0, 7, 32'h11);
        set_wr(1, 7, 32'h22);
        set_rd(0, 7);
        exp_rd("coll_byp", 0, 32'h22, 1'b1);
        drain();
        tick();
        idle();
        exp_rd("coll_arr", 0, 32'h22, 1'b1);
        drain();

        set_wr(0, 0, 32'hFF);
        set_rd(1, 0);
        exp_rd("x0_wr_byp", 1, 32'h0, 1'b1);
        drain();
        tick();
        idle();
        exp_rd("x0_wr_arr", 1, 32'h0, 1'b1);
        drain();

        bus.iss_en = 1'b1;
        bus.iss_addr = 9;
        set_rd(0, 9);
        tick();
        idle();
        exp_rd("iss_busy", 0, 32'h0, 1'b0);
        drain();
        set_wr(1, 9, 32'h33);
        exp_rd("wr_byp_rdy", 0, 32'h33, 1'b1);
        drain();
        tick();
        idle();
        exp_rd("wr_arr_rdy", 0, 32'h33, 1'b1);
        drain();
        bus.iss_en = 1'b1;
        bus.iss_addr = 9;
        set_wr(0, 9, 32'h44);
        tick();
        idle();
        set_rd(1, 9);
        exp_rd("iss_wr_same", 1, 32'h44, 1'b0);
        drain();

        for (int i = 1; i < 32; i++) begin
            idle();
            set_wr(0, AW'(i), fill(i));
            tick();
        end
        idle();
        set_rd(0, 31);
        set_rd(1, 9);
        exp_rd("fill_x31", 0, fill(31), 1'b1);
        exp_rd("fill_x9", 1, fill(9), 1'b1);
        drain();

        bus.clr_req = 1'b1;
        exp_kind("clr_req_cb", 2, 0, 1'b0);
        drain();
        for (int i = 1; i < 32; i++) begin
            tick();
            idle();
            bus.clr_req = (i == 5);
            set_wr(0, 2, 32'hBAD);
            bus.iss_en = 1'b1;
            bus.iss_addr = 20;
            set_rd(0, 2);
            set_rd(1, 31);
            exp_kind($sformatf("clr_cb_%0d", i), 2, 0, 1'b1);
            exp_kind($sformatf("clr_rdy0_%0d", i), 1, 0, 1'b0);
            exp_rd($sformatf("clr_x31_%0d", i), 1, fill(31), 1'b0);
            drain();
        end
        tick();
        idle();
        set_wr(0, 4, 32'h4444);
        set_rd(0, 2);
        set_rd(1, 20);
        exp_kind("clr_done_cb", 2, 0, 1'b0);
        exp_rd("clr_x2", 0, 32'h0, 1'b1);
        exp_rd("clr_x20", 1, 32'h0, 1'b1);
        drain();
        tick();
        idle();
        set_rd(0, 4);
        set_rd(1, 31);
        exp_rd("post_clr_wr", 0, 32'h4444, 1'b1);
        exp_rd("clr_x31", 1, 32'h0, 1'b1);
        drain();

        bus.iss_en = 1'b1;
        bus.iss_addr = 20;
        set_wr(0, 5, 32'h5555);
        tick();
        idle();
        bus.clr_req = 1'b1;
        tick();
        idle();
        for (int i = 1; i < 10; i++) tick();
        #2 rst = 1'b0;
        set_rd(0, 20);
        set_rd(1, 5);
        #1;
        exp_kind("arst_cb", 2, 0, 1'b0);
        exp_rd("arst_x20", 0, 32'h0, 1'b1);
        exp_rd("arst_x5", 1, 32'h0, 1'b1);
        drain();
        #1 rst = 1'b1;
        tick();
        bus.clr_req = 1'b1;
        tick();
        idle();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.clr_busy) n++;
            tick();
        end
        check("clr_len", n, 31);

`ifdef RVX_RF_PARITY_EN
        set_wr(0, 3, 32'h1);
        bus.perr_inject = 1'b1;
        set_rd(0, 3);
        exp_kind("perr_byp", 3, 0, 1'b0);
        drain();
        tick();
        idle();
        exp_kind("perr_inj", 3, 0, 1'b1);
        exp_rd("perr_data", 0, 32'h1, 1'b1);
        drain();
        set_wr(0, 3, 32'h1);
        tick();
        idle();
        exp_kind("perr_clean", 3, 0, 1'b0);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rv_regfile_mp.md
Name: rv_regfile_mp

Overview:
- Parametrised multi-port register file, successor to the two-read/one-write RVX regfile.
- Configurable width, depth, read-port and write-port count.
- Adds a per-register busy scoreboard, write-to-read bypass with a ready flag per read port, and a sequenced software clear.
- Sits between decode/issue (reads, issue marks) and the writeback stage(s) of the RVX pipeline.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2: number of read ports.
- NUM_WR, 2: number of write ports.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rst, input, 1: reset, asynchronous, active-low.
- wr_en, input, NUM_WR: per-port write enable.
- wr_addr, input, NUM_WR*ADDR_W: write addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- wr_data, input, NUM_WR*DATA_W: write data; port k uses bits [k*DATA_W +: DATA_W].
- rd_addr, input, NUM_RD*ADDR_W: read addresses.
- rd_data, output, NUM_RD*DATA_W: read data, combinational.
- rd_ready, output, NUM_RD: operand valid (not pending) for each read port.
- iss_en, input, 1: issue marks iss_addr as pending.
- iss_addr, input, ADDR_W: destination being issued.
- clr_req, input, 1: request a sequenced clear of all entries.
- clr_busy, output, 1: clear sequence in progress.

Behaviour:
- Entry 0: reads as 0, never busy. Writes and issues to address 0 are ignored.
- Writes:
  - Take effect at posedge clk when wr_en[k]=1 and address is nonzero.
  - Same address on several ports in one cycle: highest port index wins.
- Reads, zero latency, evaluated per port independently:
  - Address 0: rd_data=0, rd_ready=1.
  - Else, if any enabled write port targets the same address: bypass the highest-index matching wr_data, rd_ready=1.
  - Else: rd_data=regfile[addr], rd_ready = !busy[addr].
- Scoreboard, busy[DEPTH-1:1]:
  - Set at posedge by iss_en with nonzero iss_addr.
  - Cleared at posedge by any write to that address.
  - Issue and write to the same address in the same cycle: busy ends at 1 (new producer wins); data is still written.
- Clear FSM, states IDLE and CLEAR; counter cnt is ADDR_W bits.
  - IDLE: clr_req=1 → CLEAR, cnt=1.
  - CLEAR: each cycle, regfile[cnt]=0 and busy[cnt]=0. At cnt=DEPTH-1 → IDLE; otherwise cnt+1.
  - Full clear takes DEPTH-1 cycles.
  - clr_busy=1 exactly while in CLEAR.
  - During CLEAR: external writes and issues are dropped, clr_req is ignored, and rd_ready is forced to 0 on all ports (rd_data as normal, bypass disabled).
  - Returning to IDLE: writes and issues are accepted on the first IDLE cycle.
- Reset (rst=0, asynchronous, any time including mid-clear):
  - All entries = 0, busy = 0, FSM = IDLE, cnt = 0, clr_busy = 0.
  - rd_data follows the zeroed array; rd_ready = 1 for every port.
- Output values while rst=0: rd_data per read rule (all 0), rd_ready all 1, clr_busy 0.

Optional Feature:
- Macro: RVX_RF_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit computed from its written data.
  - Added output rd_perr, NUM_RD bits: 1 when the stored parity mismatches the stored data for the addressed entry.
  - rd_perr is forced to 0 for address 0, bypass hits and during CLEAR.
  - Clear and reset write parity 0 with data 0.
  - Added input perr_inject, 1 bit: when 1, port-0 writes store inverted parity.
- Undefined: no parity storage; rd_perr and perr_inject ports are absent.

Test Plan:
- Basic write/read: reset; write port0 x5=0xDEADBEEF; next cycle read x5 on port1 → 0xDEADBEEF, rd_ready=1; read x0 → 0, rd_ready=1.
- Write collision and bypass: same cycle wr port0 x7=0x11, wr port1 x7=0x22, read x7 → bypass 0x22; next cycle read x7 → 0x22.
- Scoreboard: iss x9 → next cycle rd_ready(x9)=0. Write x9=0x33 → same cycle rd_ready=1 via bypass, next cycle rd_ready=1 from array. Simultaneous iss x9 + write x9=0x44 → next cycle data 0x44, rd_ready=0.
- Clear: fill x1..x31, clr_req pulse → clr_busy=1 for 31 cycles, writes in that window dropped, rd_ready=0. After completion all reads 0, rd_ready=1.
- Reset mid-operation: assert rst asynchronously at cnt=10 during CLEAR with x20 busy → immediately clr_busy=0, all reads 0, rd_ready=1. After release, a new clr_req starts from cnt=1.
- With RVX_RF_PARITY_EN: write x3=0x1 with perr_inject=1 → read x3 gives rd_perr=1. Rewrite x3 with perr_inject=0 → rd_perr=0.
